// File: rtl/param_demux_pkg.sv
// Shared types and default sizing for the parameterised one-to-N demultiplexer.
// The optional drop counter is enabled by defining PARAM_DEMUX_STATS_EN.
package param_demux_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int DEFAULT_INPUT_WIDTH    = 32;
    localparam int DEFAULT_SELECTOR_WIDTH = 2;
    localparam int DEFAULT_SIGNAL_COUNT   = 4;
    localparam int DROP_COUNT_WIDTH       = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot of the demultiplexer: loads a word, holds it while the
// consumer stalls, and drains on valid && ready. A load may coincide with a drain.
module demux_slot
    import param_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_INPUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_t      state_reg;
    slot_state_t      state_next;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SLOT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // The parent only asserts load when the slot is empty or draining this cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SLOT_EMPTY: if (load)           state_next = SLOT_FULL;
            SLOT_FULL:  if (!load && ready) state_next = SLOT_EMPTY;
            default:                        state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
        end
    end

    assign data  = data_reg;
    assign valid = (state_reg == SLOT_FULL);

endmodule

// File: rtl/dut_param_demux.sv
// Fixed 32-bit, 4-channel wrapper with flat per-channel ports for external test harnesses.
// PARAM_DEMUX_STATS_EN exposes drop_count_o.
module dut_param_demux
    import param_demux_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  sel_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3,
    output logic [31:0] out4,
    output logic [3:0]  valid_o,
    input  logic [3:0]  ready_i,
    output logic        err_o
`ifdef PARAM_DEMUX_STATS_EN
    ,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count_o
`endif
);

    logic [31:0] outputs [4];

    param_demux #(
        .INPUT_WIDTH    (32),
        .SELECTOR_WIDTH (2),
        .SIGNAL_COUNT   (4)
    ) u_demux (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .outputs (outputs),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
`ifdef PARAM_DEMUX_STATS_EN
        ,
        .drop_count_o (drop_count_o)
`endif
    );

    assign out1 = outputs[0];
    assign out2 = outputs[1];
    assign out3 = outputs[2];
    assign out4 = outputs[3];

endmodule

// File: rtl/param_demux.sv
// Routes each inbound word to one of SIGNAL_COUNT independent one-entry slots.
// Out-of-range selectors are dropped with an err_o pulse; PARAM_DEMUX_STATS_EN adds drop_count_o.
module param_demux
    import param_demux_pkg::*;
#(
    parameter int INPUT_WIDTH    = DEFAULT_INPUT_WIDTH,
    parameter int SELECTOR_WIDTH = DEFAULT_SELECTOR_WIDTH,
    parameter int SIGNAL_COUNT   = DEFAULT_SIGNAL_COUNT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [INPUT_WIDTH-1:0]    data_i,
    input  logic [SELECTOR_WIDTH-1:0] sel_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [INPUT_WIDTH-1:0]    outputs [SIGNAL_COUNT],
    output logic [SIGNAL_COUNT-1:0]   valid_o,
    input  logic [SIGNAL_COUNT-1:0]   ready_i,
    output logic                      err_o
`ifdef PARAM_DEMUX_STATS_EN
    ,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count_o
`endif
);

    // One extra bit so SIGNAL_COUNT == 2**SELECTOR_WIDTH is representable.
    localparam logic [SELECTOR_WIDTH:0] COUNT_EXT = (SELECTOR_WIDTH + 1)'(SIGNAL_COUNT);

    logic                    in_range;
    logic                    accept;
    logic                    err_reg;
    logic [SIGNAL_COUNT-1:0] sel_match;
    logic [SIGNAL_COUNT-1:0] slot_room;
    logic [SIGNAL_COUNT-1:0] load;

    assign in_range = ({1'b0, sel_i} < COUNT_EXT);

    generate
        for (genvar gi = 0; gi < SIGNAL_COUNT; gi++) begin : g_slot
            assign sel_match[gi] = (sel_i == SELECTOR_WIDTH'(gi));
            assign slot_room[gi] = !valid_o[gi] || ready_i[gi];
            assign load[gi]      = valid_i && sel_match[gi] && slot_room[gi];

            demux_slot #(
                .WIDTH (INPUT_WIDTH)
            ) u_slot (
                .clk       (clk_i),
                .rst       (rst_i),
                .load      (load[gi]),
                .load_data (data_i),
                .ready     (ready_i[gi]),
                .data      (outputs[gi]),
                .valid     (valid_o[gi])
            );
        end
    endgenerate

    // Depends only on sel_i, slot state and ready_i, never on valid_i.
    assign ready_o = !in_range || |(sel_match & slot_room);
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept && !in_range;
        end
    end

    assign err_o = err_reg;

`ifdef PARAM_DEMUX_STATS_EN
    logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_count_reg <= '0;
        end else if (accept && !in_range && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

    assign drop_count_o = drop_count_reg;
`endif

endmodule

// File: tb/tb_param_demux.sv
// Bench for param_demux: a 4-channel instance checked through per-channel
// expectation queues, plus a 3-channel instance for out-of-range drops.
module tb_param_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [31:0] data_i;
    logic [1:0]  sel_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] outputs [4];
    logic [3:0]  valid_o;
    logic [3:0]  ready_i;
    logic        err_o;

    logic [31:0] data3;
    logic [1:0]  sel3;
    logic        valid3;
    logic        ready3;
    logic [31:0] outputs3 [3];
    logic [2:0]  valid3_o;
    logic [2:0]  ready3_i;
    logic        err3;

`ifdef PARAM_DEMUX_STATS_EN
    logic [15:0] drop4;
    logic [15:0] drop3;
`endif

    int errors = 0;
    int checks = 0;
    int err_expect = 0;
    logic [31:0] exp_q [4][$];

    param_demux #(.INPUT_WIDTH(32), .SELECTOR_WIDTH(2), .SIGNAL_COUNT(4)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .outputs (outputs),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
`ifdef PARAM_DEMUX_STATS_EN
        ,
        .drop_count_o (drop4)
`endif
    );

    param_demux #(.INPUT_WIDTH(32), .SELECTOR_WIDTH(2), .SIGNAL_COUNT(3)) u_dut3 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data3),
        .sel_i   (sel3),
        .valid_i (valid3),
        .ready_o (ready3),
        .outputs (outputs3),
        .valid_o (valid3_o),
        .ready_i (ready3_i),
        .err_o   (err3)
`ifdef PARAM_DEMUX_STATS_EN
        ,
        .drop_count_o (drop3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a word to the 4-channel instance until accepted; returns cycles waited.
    task automatic send(input logic [1:0] s, input logic [31:0] d, output int waits);
        data_i  = d;
        sel_i   = s;
        valid_i = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (!ready_o && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ch%0d: ready_o=%b required 1", s, ready_o);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[s].push_back(d);
        #1 valid_i = 1'b0;
    endtask

    // Monitor: every channel transfer and every err pulse is matched against expectations.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (valid_o[k] && ready_i[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word ch%0d: got %h required none", k, outputs[k]);
                    end else begin
                        check($sformatf("xfer ch%0d", k), outputs[k], exp_q[k].pop_front());
                    end
                end
            end
            if (err_o) begin
                checks++;
                errors++;
                $display("FAIL err4: got err_o=1 required 0");
            end
            if (err3) begin
                checks++;
                if (err_expect > 0) begin
                    err_expect--;
                    $display("ok   err3 pulse");
                end else begin
                    errors++;
                    $display("FAIL err3_unexpected: got 1 required 0");
                end
            end
        end
    end

    logic [1:0]  mix_ch   [6] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0};
    logic [31:0] mix_data [6] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                  32'h1000_0003, 32'h1000_0004, 32'h1000_0005};

    initial begin
        int w;
        rst_i    = 1'b1;
        data_i   = '0;
        sel_i    = '0;
        valid_i  = 1'b0;
        ready_i  = 4'b1111;
        data3    = '0;
        sel3     = '0;
        valid3   = 1'b0;
        ready3_i = 3'b111;

        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o", valid_o, 4'b0000);
        check("reset err_o", err_o, 1'b0);
        check("reset ready_o", ready_o, 1'b1);
        for (int k = 0; k < 4; k++) check($sformatf("reset outputs[%0d]", k), outputs[k], 32'h0);
        check("reset valid3_o", valid3_o, 3'b000);
        rst_i = 1'b0;
        tick();

        // Single word to channel 2 appears exactly one cycle after acceptance.
        send(2'd2, 32'hA5A5_0001, w);
        check("basic valid_o", valid_o, 4'b0100);
        check("basic outputs[2]", outputs[2], 32'hA5A5_0001);
        tick();
        check("basic valid_o after", valid_o, 4'b0000);

        // Stalled channel 1: second word is refused until the consumer is ready.
        ready_i = 4'b1101;
        send(2'd1, 32'h11, w);
        data_i  = 32'h22;
        sel_i   = 2'd1;
        valid_i = 1'b1;
        @(negedge clk);
        check("stall ready_o", ready_o, 1'b0);
        check("stall outputs[1]", outputs[1], 32'h11);
        @(posedge clk);
        @(negedge clk);
        check("stall hold outputs[1]", outputs[1], 32'h11);
        check("stall hold ready_o", ready_o, 1'b0);
        @(posedge clk);
        #1 ready_i = 4'b1111;
        send(2'd1, 32'h22, w);
        check("stall release waits", w, 0);
        check("stall outputs[1] new", outputs[1], 32'h22);
        tick();

        // Channel 0 full and stalled must not block channel 3.
        ready_i = 4'b1110;
        send(2'd0, 32'h44, w);
        send(2'd3, 32'h33, w);
        check("indep waits", w, 0);
        check("indep valid_o", valid_o, 4'b1001);
        check("indep outputs[0]", outputs[0], 32'h44);
        tick();
        check("indep valid_o drained", valid_o, 4'b0001);
        check("indep outputs[0] held", outputs[0], 32'h44);
        ready_i = 4'b1111;
        tick();
        check("indep valid_o empty", valid_o, 4'b0000);

        // Zero-bubble reload on a full slot draining in the same cycle.
        ready_i = 4'b1011;
        send(2'd2, 32'h55, w);
        tick();
        check("bubble full valid_o", valid_o, 4'b0100);
        ready_i = 4'b1111;
        send(2'd2, 32'h66, w);
        check("bubble waits", w, 0);
        check("bubble valid_o", valid_o, 4'b0100);
        check("bubble outputs[2]", outputs[2], 32'h66);
        tick();

        // Back-to-back mixed traffic, order checked by the monitor.
        for (int i = 0; i < 6; i++) begin
            send(mix_ch[i], mix_data[i], w);
            check($sformatf("mix waits %0d", i), w, 0);
        end
        tick();

        // Out-of-range selector on the 3-channel instance.
        data3  = 32'hDEAD_BEEF;
        sel3   = 2'd3;
        valid3 = 1'b1;
        @(negedge clk);
        check("oor ready3", ready3, 1'b1);
        check("oor err3 before", err3, 1'b0);
        @(posedge clk);
        err_expect++;
        #1 valid3 = 1'b0;
        check("oor err3", err3, 1'b1);
        check("oor valid3_o", valid3_o, 3'b000);
`ifdef PARAM_DEMUX_STATS_EN
        check("oor drop3", drop3, 16'd1);
`endif
        tick();
        check("oor err3 clear", err3, 1'b0);
        data3  = 32'hCAFE_0002;
        sel3   = 2'd2;
        valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        check("dut3 valid3_o", valid3_o, 3'b100);
        check("dut3 outputs3[2]", outputs3[2], 32'hCAFE_0002);
        check("dut3 err3", err3, 1'b0);
        tick();

        // Asynchronous reset while channels 1 and 3 hold words.
        ready_i = 4'b0000;
        send(2'd1, 32'h77, w);
        send(2'd3, 32'h88, w);
        check("arst valid_o before", valid_o, 4'b1010);
        #2 rst_i = 1'b1;
        #1;
        check("arst valid_o", valid_o, 4'b0000);
        check("arst outputs[1]", outputs[1], 32'h0);
        check("arst outputs[3]", outputs[3], 32'h0);
        check("arst ready_o", ready_o, 1'b1);
        exp_q[1].delete();
        exp_q[3].delete();
        @(posedge clk);
        #1 rst_i = 1'b0;
        ready_i = 4'b1111;
        send(2'd0, 32'h99, w);
        check("post-reset valid_o", valid_o, 4'b0001);
        check("post-reset outputs[0]", outputs[0], 32'h99);
        tick();
        tick();

        for (int k = 0; k < 4; k++) check($sformatf("drained ch%0d", k), exp_q[k].size(), 0);
        check("err pulses consumed", err_expect, 0);
`ifdef PARAM_DEMUX_STATS_EN
        check("drop4", drop4, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
